// File: rtl/unread_stream_sink_pkg.sv
// unread_stream_sink_pkg
//   Shared helpers for the unread stream sink:
//     phase_width() - width of the ready-phase counter ($clog2 of the period,
//                     never less than 1 bit).
//     fold()        - XOR-folds a payload into signature-sized chunks,
//                     starting at the LSB, with the top chunk zero-padded.
//   fold() works on fixed maximum widths (FoldMaxData / FoldMaxSig); callers
//   zero-extend their payload and cast the result down to their own width.
package unread_stream_sink_pkg;

    localparam int FoldMaxData = 512;
    localparam int FoldMaxSig  = 256;

    function automatic int phase_width(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

    // Bit i of the payload lands in signature bit (i mod sig_w), which is
    // exactly the chunk-wise XOR with a zero-padded top chunk.
    function automatic logic [FoldMaxSig-1:0] fold(
        input logic [FoldMaxData-1:0] data,
        input int                     data_w,
        input int                     sig_w
    );
        logic [FoldMaxSig-1:0] res;
        res = '0;
        for (int i = 0; i < FoldMaxData; i++) begin
            if (i < data_w) begin
                res[i % sig_w] = res[i % sig_w] ^ data[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/unread_sat_counter.sv
// unread_sat_counter
//   Saturating accepted-beat counter with sticky overflow.
//   Ports:
//     clk_i      clock
//     rst_i      asynchronous active-high reset
//     clear_i    synchronous clear of count and overflow
//     inc_i      count one beat this cycle
//     cnt_o      current count (holds at all-ones)
//     overflow_o set when a beat arrives while the count is all-ones
module unread_sat_counter #(
    parameter int CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                inc_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                overflow_o
);

    logic [CntWidth-1:0] cnt_q;
    logic                ovf_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clear_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (inc_i) begin
            if (cnt_q == '1) begin
                ovf_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q + CntWidth'(1);
            end
        end
    end

    assign cnt_o      = cnt_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/unread_stream_sink.sv
// unread_stream_sink
//   Terminates unused valid/ready streams: accepts beats on a shared ready
//   pattern (one cycle in every ReadyPeriod), discards them, counts them per
//   channel and folds all accepted payloads into a rotating XOR signature so
//   the producing logic stays observable and is not pruned.
//   Ports:
//     clk_i       clock
//     rst_i       asynchronous active-high reset
//     clear_i     synchronous clear of phase, counters, overflow, signature, last
//     valid_i     per-channel beat valid
//     data_i      per-channel payload, channel c at [c*DataWidth +: DataWidth]
//     ready_o     per-channel ready (shared phase, low during clear)
//     cnt_o       per-channel accepted-beat count, channel c at [c*CntWidth +: CntWidth]
//     overflow_o  per-channel sticky counter overflow
//     sig_o       data signature
//     last_o      last accepted payload (lowest firing channel)
//   Optional feature: define UNREAD_STREAM_SINK_LAST_EN to build the last_o
//   register; otherwise last_o is constant zero.
//   Limits: DataWidth <= 512, SigWidth <= 256 (fold helper widths).
module unread_stream_sink
    import unread_stream_sink_pkg::*;
#(
    parameter int NumChan     = 2,
    parameter int DataWidth   = 32,
    parameter int CntWidth    = 16,
    parameter int SigWidth    = 32,
    parameter int ReadyPeriod = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          clear_i,
    input  logic [NumChan-1:0]            valid_i,
    input  logic [NumChan*DataWidth-1:0]  data_i,
    output logic [NumChan-1:0]            ready_o,
    output logic [NumChan*CntWidth-1:0]   cnt_o,
    output logic [NumChan-1:0]            overflow_o,
    output logic [SigWidth-1:0]           sig_o,
    output logic [DataWidth-1:0]          last_o
);

    logic               phase_zero;
    logic [NumChan-1:0] fire;
    logic [SigWidth-1:0] fold_acc;
    logic [SigWidth-1:0] sig_q;

    // Ready phase: one shared counter, no flops at all when always ready.
    if (ReadyPeriod > 1) begin : g_phase
        localparam int PhaseW = phase_width(ReadyPeriod);
        logic [PhaseW-1:0] phase_q;

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                phase_q <= '0;
            end else if (clear_i) begin
                phase_q <= '0;
            end else if (phase_q == PhaseW'(ReadyPeriod - 1)) begin
                phase_q <= '0;
            end else begin
                phase_q <= phase_q + PhaseW'(1);
            end
        end

        assign phase_zero = (phase_q == '0);
    end else begin : g_no_phase
        assign phase_zero = 1'b1;
    end

    // Ready never looks at valid, so there is no combinational loop back to
    // the producer; clear blocks every handshake for that cycle.
    assign ready_o = {NumChan{phase_zero & ~clear_i}};
    assign fire    = valid_i & ready_o;

    for (genvar c = 0; c < NumChan; c++) begin : g_cnt
        unread_sat_counter #(
            .CntWidth(CntWidth)
        ) u_cnt (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .clear_i   (clear_i),
            .inc_i     (fire[c]),
            .cnt_o     (cnt_o[c*CntWidth +: CntWidth]),
            .overflow_o(overflow_o[c])
        );
    end

    // All beats firing in one cycle are absorbed into a single update.
    always_comb begin
        fold_acc = '0;
        for (int c = 0; c < NumChan; c++) begin
            if (fire[c]) begin
                fold_acc = fold_acc ^ SigWidth'(fold(
                    FoldMaxData'(data_i[c*DataWidth +: DataWidth]), DataWidth, SigWidth));
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q <= '0;
        end else if (clear_i) begin
            sig_q <= '0;
        end else begin
            sig_q <= {sig_q[SigWidth-2:0], sig_q[SigWidth-1]} ^ fold_acc;
        end
    end

    assign sig_o = sig_q;

`ifdef UNREAD_STREAM_SINK_LAST_EN
    logic [DataWidth-1:0] last_q;
    logic [DataWidth-1:0] last_d;

    // Scan from the top so the lowest-index firing channel wins.
    always_comb begin
        last_d = last_q;
        for (int c = NumChan - 1; c >= 0; c--) begin
            if (fire[c]) begin
                last_d = data_i[c*DataWidth +: DataWidth];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_q <= '0;
        end else if (clear_i) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_o = last_q;
`else
    assign last_o = '0;
`endif

endmodule

// File: tb/tb_unread_stream_sink.sv
module tb_unread_stream_sink;

    logic        clk;
    logic        rst;
    logic        clear;
    logic [1:0]  valid;
    logic [63:0] data;

    // u_a: defaults; u_b: ReadyPeriod=3; u_c: CntWidth=2.
    logic [1:0]  ready_a, ready_b, ready_c;
    logic [31:0] cnt_a, cnt_b;
    logic [3:0]  cnt_c;
    logic [1:0]  ovf_a, ovf_b, ovf_c;
    logic [31:0] sig_a, sig_b, sig_c;
    logic [31:0] last_a, last_b, last_c;

    int checks = 0;
    int errors = 0;

    unread_stream_sink #(.NumChan(2), .DataWidth(32), .CntWidth(16), .SigWidth(32), .ReadyPeriod(1)) u_a (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .valid_i(valid), .data_i(data),
        .ready_o(ready_a), .cnt_o(cnt_a), .overflow_o(ovf_a), .sig_o(sig_a), .last_o(last_a));

    unread_stream_sink #(.NumChan(2), .DataWidth(32), .CntWidth(16), .SigWidth(32), .ReadyPeriod(3)) u_b (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .valid_i(valid), .data_i(data),
        .ready_o(ready_b), .cnt_o(cnt_b), .overflow_o(ovf_b), .sig_o(sig_b), .last_o(last_b));

    unread_stream_sink #(.NumChan(2), .DataWidth(32), .CntWidth(2), .SigWidth(32), .ReadyPeriod(1)) u_c (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .valid_i(valid), .data_i(data),
        .ready_o(ready_c), .cnt_o(cnt_c), .overflow_o(ovf_c), .sig_o(sig_c), .last_o(last_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic [1:0]  vld;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] exp_sig;
        logic [31:0] exp_last;   // value when the last_o register is built
        logic [15:0] exp_cnt0;
        logic [15:0] exp_cnt1;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] last_exp(input logic [31:0] v);
`ifdef UNREAD_STREAM_SINK_LAST_EN
        return v;
`else
        return (v & 32'h0);
`endif
    endfunction

    task automatic do_clear();
        clear = 1'b1;
        valid = 2'b11;
        #1;
        chk("ready_a_in_clear", 64'(ready_a), 64'(2'b00));
        chk("ready_b_in_clear", 64'(ready_b), 64'(2'b00));
        chk("ready_c_in_clear", 64'(ready_c), 64'(2'b00));
        tick();
        clear = 1'b0;
        valid = 2'b00;
    endtask

    initial begin
        // {clr, vld, d0, d1, exp_sig, exp_last, exp_cnt0, exp_cnt1}
        vecs[0] = '{1'b0, 2'b01, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF, 16'd1, 16'd0};
        vecs[1] = '{1'b0, 2'b00, 32'h0,        32'h0,        32'hBD5B7DDF, 32'hDEADBEEF, 16'd1, 16'd0};
        vecs[2] = '{1'b1, 2'b00, 32'h0,        32'h0,        32'h00000000, 32'h00000000, 16'd0, 16'd0};
        vecs[3] = '{1'b0, 2'b11, 32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFF, 32'h0000FFFF, 16'd1, 16'd1};
        vecs[4] = '{1'b0, 2'b00, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h0000FFFF, 16'd1, 16'd1};
        vecs[5] = '{1'b0, 2'b10, 32'h0,        32'h00000001, 32'hFFFFFFFE, 32'h00000001, 16'd1, 16'd2};
        vecs[6] = '{1'b0, 2'b01, 32'h80000000, 32'h12345678, 32'h7FFFFFFD, 32'h80000000, 16'd2, 16'd2};
        vecs[7] = '{1'b0, 2'b00, 32'hAAAA5555, 32'h5555AAAA, 32'hFFFFFFFA, 32'h80000000, 16'd2, 16'd2};

        rst   = 1'b1;
        clear = 1'b0;
        valid = 2'b00;
        data  = '0;
        tick();
        tick();
        chk("rst_cnt_a", 64'(cnt_a), 64'h0);
        chk("rst_ovf_a", 64'(ovf_a), 64'h0);
        chk("rst_sig_a", 64'(sig_a), 64'h0);
        chk("rst_last_a", 64'(last_a), 64'h0);
        chk("rst_cnt_c", 64'(cnt_c), 64'h0);
        rst = 1'b0;
        #1;

        // Always-ready streaming on both channels; equal data keeps sig at 0.
        valid = 2'b11;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("ready_a_stream_%0d", k), 64'(ready_a), 64'(2'b11));
            tick();
        end
        valid = 2'b00;
        chk("cnt_a_ch0_10", 64'(cnt_a[15:0]), 64'd10);
        chk("cnt_a_ch1_10", 64'(cnt_a[31:16]), 64'd10);
        chk("ovf_a_none", 64'(ovf_a), 64'h0);
        chk("ovf_c_sat", 64'(ovf_c), 64'(2'b11));
        do_clear();
        chk("cnt_c_cleared", 64'(cnt_c), 64'h0);
        chk("ovf_c_cleared", 64'(ovf_c), 64'h0);

        // ReadyPeriod=3: ready on cycles 0, 3, 6 only.
        valid = 2'b01;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk($sformatf("ready_b_phase_%0d", k), 64'(ready_b), 64'((k % 3 == 0) ? 2'b11 : 2'b00));
            tick();
        end
        valid = 2'b00;
        chk("cnt_b_ch0_3", 64'(cnt_b[15:0]), 64'd3);
        chk("cnt_b_ch1_0", 64'(cnt_b[31:16]), 64'd0);
        do_clear();

        // CntWidth=2 saturation and sticky overflow on channel 1.
        valid = 2'b10;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("cnt_c_ch1_beat%0d", k + 1), 64'(cnt_c[3:2]), 64'((k < 3) ? k + 1 : 3));
            chk($sformatf("ovf_c_ch1_beat%0d", k + 1), 64'(ovf_c[1]), 64'((k >= 3) ? 1 : 0));
        end
        valid = 2'b00;
        tick();
        chk("ovf_c_sticky", 64'(ovf_c), 64'(2'b10));
        do_clear();
        chk("cnt_c_clr2", 64'(cnt_c), 64'h0);
        chk("ovf_c_clr2", 64'(ovf_c), 64'h0);

        // Signature / last-payload vectors on u_a (starts from cleared state).
        for (int i = 0; i < 8; i++) begin
            clear = vecs[i].clr;
            valid = vecs[i].vld;
            data  = {vecs[i].d1, vecs[i].d0};
            tick();
            chk($sformatf("vec%0d_sig", i), 64'(sig_a), 64'(vecs[i].exp_sig));
            chk($sformatf("vec%0d_last", i), 64'(last_a), 64'(last_exp(vecs[i].exp_last)));
            chk($sformatf("vec%0d_cnt0", i), 64'(cnt_a[15:0]), 64'(vecs[i].exp_cnt0));
            chk($sformatf("vec%0d_cnt1", i), 64'(cnt_a[31:16]), 64'(vecs[i].exp_cnt1));
        end
        clear = 1'b0;
        valid = 2'b00;

        // Asynchronous reset mid-traffic.
        do_clear();
        valid = 2'b11;
        data  = {32'h00000002, 32'h00000001};
        tick();
        tick();
        tick();
        chk("pre_rst_cnt_a", 64'(cnt_a[15:0]), 64'd3);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_cnt_a", 64'(cnt_a), 64'h0);
        chk("async_rst_sig_a", 64'(sig_a), 64'h0);
        chk("async_rst_last_a", 64'(last_a), 64'h0);
        chk("async_rst_cnt_b", 64'(cnt_b), 64'h0);
        chk("async_rst_ovf_c", 64'(ovf_c), 64'h0);
        tick();
        rst = 1'b0;
        valid = 2'b01;
        #1;
        chk("post_rst_ready_b", 64'(ready_b), 64'(2'b11));
        tick();
        chk("post_rst_cnt_b", 64'(cnt_b[15:0]), 64'd1);
        #1;
        chk("post_rst_ready_b_ph1", 64'(ready_b), 64'(2'b00));
        tick();
        chk("post_rst_cnt_a", 64'(cnt_a[15:0]), 64'd2);
        valid = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
